// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO block.
//   UART_DW       : byte width used on the host and transmitter sides
//   tx_state_e    : request sequencer states (idle, request pulse, wait for done)
package uart_tx_fifo_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count.
//   clk, rst          : clock, asynchronous active-low reset
//   wr_en, wr_data    : enqueue request (ignored while full)
//   rd_en             : dequeue request (ignored while empty)
//   rd_data           : head entry, valid whenever empty is low
//   count             : number of entries held
//   full, empty       : occupancy flags
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DW-1:0]                wr_data,
  input  logic                         rd_en,
  output logic [DW-1:0]                rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_fire;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; stale entries are unreachable because count
  // gates every read, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and request sequencer feeding the UART transmitter.
//   clk, rst           : clock, asynchronous active-low reset
//   wr_valid, wr_data  : host byte write; accepted when wr_ready is high
//   wr_ready           : FIFO not full
//   tx_req             : one-cycle frame start request to the transmitter
//   din                : byte for the transmitter, held from tx_req to tx_done
//   tx_done            : transmitter frame-finished pulse (ignored unless waiting)
//   count              : bytes queued, excluding the one in flight
//   busy               : bytes queued or a frame in flight
//   overflow           : sticky, set by a write attempt while full
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = UART_DW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  input  logic [DW-1:0]               wr_data,
  output logic                        wr_ready,
  output logic                        tx_req,
  output logic [DW-1:0]               din,
  input  logic                        tx_done,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        busy,
  output logic                        overflow
);

  tx_state_e     state;
  tx_state_e     next_state;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_fire;
  logic [DW-1:0] head;

  assign wr_ready = !full;
  assign wr_fire  = wr_valid && !full;
  assign busy     = (state != ST_IDLE) || !empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // NOTE: defaults first so no path through the case leaves a variable
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = ST_REQ;
        end
      end
      ST_REQ:  next_state = ST_WAIT;
      ST_WAIT: if (tx_done) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // tx_req is a flop so the transmitter sees a glitch-free single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_req <= 1'b0;
      din    <= '0;
    end else begin
      tx_req <= (next_state == ST_REQ);
      if (pop) din <= head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  overflow <= 1'b0;
    else if (wr_valid && full) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: randomized and directed scenarios
// compared every cycle against a queue-based behavioural model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  typedef logic [CW+12-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          tx_req;
  logic [7:0]    din;
  logic          tx_done;
  logic [CW-1:0] count;
  logic          busy;
  logic          overflow;

  uart_tx_fifo #(.DEPTH(DEPTH), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx_req   (tx_req),
    .din      (din),
    .tx_done  (tx_done),
    .count    (count),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: queued bytes, phase of the frame (0 idle, 1 requesting, 2 in flight),
  // byte handed to the transmitter, sticky overflow.
  logic [7:0] byte_q[$];
  int         m_phase;
  logic [7:0] m_din;
  logic       m_ovf;

  task automatic model_reset();
    byte_q.delete();
    m_phase = 0;
    m_din   = 8'h00;
    m_ovf   = 1'b0;
  endtask

  function automatic vec_t exp_vec();
    return {CW'(byte_q.size()), (byte_q.size() < DEPTH), (m_phase == 1), m_din,
            (m_phase != 0 || byte_q.size() > 0), m_ovf};
  endfunction

  function automatic vec_t obs_vec();
    return {count, wr_ready, tx_req, din, busy, overflow};
  endfunction

  // Drive one cycle of inputs, advance the model by the same clock edge,
  // and return at 1ns after the edge with inputs idled.
  task automatic tick(input logic wv, input logic [7:0] wd, input logic td);
    int pre;
    wr_valid = wv;
    wr_data  = wd;
    tx_done  = td;
    pre = byte_q.size();
    if (wv && pre == DEPTH) m_ovf = 1'b1;
    case (m_phase)
      0: if (pre > 0) begin m_din = byte_q.pop_front(); m_phase = 1; end
      1: m_phase = 2;
      default: if (td) m_phase = 0;
    endcase
    if (wv && pre < DEPTH) byte_q.push_back(wd);
    @(posedge clk);
    #1;
    cyc++;
    wr_valid = 1'b0;
    tx_done  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
    model_reset();
    #3;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_hold got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
    #7 rst = 1'b1;
    @(posedge clk); #1;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_single();
    tick(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick(1'b0, 8'h00, 1'b0);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_cycle%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (i == 1 && (tx_req !== 1'b1 || din !== 8'hA5)) begin
        failures++;
        $display("FAIL single_req_latency got req=%b din=%h want req=1 din=a5", tx_req, din);
      end
      if (i == 1) checks++;
    end
    tick(1'b0, 8'h00, 1'b1);
    if (busy !== 1'b0 || din !== 8'hA5) begin
      failures++;
      $display("FAIL single_done got busy=%b din=%h want busy=0 din=a5", busy, din);
    end
    checks++;
  endtask

  task automatic test_burst();
    int peak = 0;
    int nxt  = 1;
    for (int i = 0; i < 200 && (i < 16 || busy === 1'b1); i++) begin
      if (i < 16) tick(1'b1, 8'(i + 1), 1'b0);
      else        tick(1'b0, 8'h00, (m_phase == 2) && ($urandom_range(0, 1) == 1));
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL burst_cycle%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (i < 16 && int'(count) > peak) peak = int'(count);
      if (i < 16 && wr_ready !== 1'b1) begin
        failures++;
        $display("FAIL burst_ready cycle%0d got=%b want=1", i, wr_ready);
      end
      if (tx_req === 1'b1) begin
        if (din !== 8'(nxt)) begin
          failures++;
          $display("FAIL burst_order got=%h want=%h", din, 8'(nxt));
        end
        checks++;
        nxt++;
      end
    end
    if (peak != 15 || nxt != 17 || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL burst_summary got peak=%0d sent=%0d busy=%b ovf=%b want 15 16 0 0",
               peak, nxt - 1, busy, overflow);
    end
    checks++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 18; i++) begin
      tick(1'b1, 8'($urandom), 1'b0);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ovf_write%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (i == 17 && (count !== CW'(16) || wr_ready !== 1'b0 || overflow !== 1'b0)) begin
        failures++;
        $display("FAIL ovf_full got cnt=%0d rdy=%b ovf=%b want 16 0 0", count, wr_ready, overflow);
      end
      if (i == 18 && (count !== CW'(16) || overflow !== 1'b1)) begin
        failures++;
        $display("FAIL ovf_set got cnt=%0d ovf=%b want 16 1", count, overflow);
      end
      if (i >= 17) checks++;
    end
    for (int i = 0; i < 300 && busy === 1'b1; i++) begin
      tick(1'b0, 8'h00, (m_phase == 2) && ($urandom_range(0, 2) == 0));
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ovf_drain%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
    end
    if (busy !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got busy=%b ovf=%b want 0 1", busy, overflow);
    end
    checks++;
  endtask

  // Heavy random traffic keeps the FIFO near full so pops coincide with writes
  // across pointer wrap; spurious tx_done is sprinkled outside the wait phase.
  task automatic test_wrap();
    for (int i = 0; i < 16; i++) tick(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 300; i++) begin
      logic td;
      td = (m_phase == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      tick($urandom_range(0, 9) < 8, 8'($urandom), td);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL wrap_cycle%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
    end
    for (int i = 0; i < 300 && busy === 1'b1; i++)
      tick(1'b0, 8'h00, m_phase == 2);
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_drain got busy=%b want 0", busy);
    end
    checks++;
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL spur_idle got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
    tick(1'b1, 8'h3C, 1'b1);
    tick(1'b1, 8'hC3, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    if (obs_vec() !== exp_vec() || tx_req !== 1'b0 || busy !== 1'b1 || din !== 8'h3C) begin
      failures++;
      $display("FAIL spur_req got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0);
    if (obs_vec() !== exp_vec() || count !== CW'(1)) begin
      failures++;
      $display("FAIL spur_wait got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
    for (int i = 0; i < 20 && busy === 1'b1; i++) tick(1'b0, 8'h00, m_phase == 2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom), 1'b0);
    if (count !== CW'(5) || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_prep got cnt=%0d busy=%b want 5 1", count, busy);
    end
    checks++;
    #2 rst = 1'b0;
    model_reset();
    #1;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL mid_async got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
    @(posedge clk);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (obs_vec() !== exp_vec() || tx_req !== 1'b0) begin
        failures++;
        $display("FAIL mid_after%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
    end
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    if (obs_vec() !== exp_vec() || tx_req !== 1'b1 || din !== 8'h5A) begin
      failures++;
      $display("FAIL mid_resume got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
